qdrc_phy_burst_align_multi: RTL and testbench
=============================================

Name: qdrc_phy_burst_align_multi

Overview:
Next-generation QDR PHY burst aligner. It writes known DDR burst patterns to address 0 and reads them back. From the returned data it finds, per data bit, how many extra cycles (0..MAX_SKEW) that bit arrives late. It then delays every bit so the whole bus lands at one common latency. Sits between the bit-align stage and the QDR controller; repeats the measurement over NUM_TRIALS and flags bits that are inconsistent or never match.

Parameters:
DATA_WIDTH, 18, QDR data width.
BW_WIDTH, 2, byte-write enable width.
ADDR_WIDTH, 21, QDR address width.
READ_LATENCY, 9, cycles from the qdr_r_n low cycle to the earliest possible first read beat at qdr_q_*.
MAX_SKEW, 3, largest extra per-bit delay searched; valid range 1..7.
NUM_TRIALS, 4, write/read passes; must be even and >= 2.
BYPASS, 0, 1 = no calibration.

Ports:
clk  in  1  PHY clock.
reset  in  1  asynchronous, active-high reset.
burst_align_start  in  1  single-cycle start pulse.
burst_align_done  out  1  calibration finished successfully.
burst_align_fail  out  1  calibration finished with one or more failing bits.
burst_align_bit_fail  out  DATA_WIDTH  per-bit failure flags.
qdr_d_rise  out  DATA_WIDTH  write data, rising edge.
qdr_d_fall  out  DATA_WIDTH  write data, falling edge.
qdr_q_rise  in  DATA_WIDTH  read data, rising edge (bit-aligned).
qdr_q_fall  in  DATA_WIDTH  read data, falling edge.
qdr_bw_n_rise  out  BW_WIDTH  byte enables, rising edge; 0 during writes.
qdr_bw_n_fall  out  BW_WIDTH  byte enables, falling edge; 0 during writes.
qdr_w_n  out  1  write strobe, active low.
qdr_r_n  out  1  read strobe, active low.
qdr_sa  out  ADDR_WIDTH  address; always 0.
qdr_q_rise_cal  out  DATA_WIDTH  aligned read data, rising edge.
qdr_q_fall_cal  out  DATA_WIDTH  aligned read data, falling edge.

Behaviour:
- Reset (async): done=0, fail=0, bit_fail=0, w_n=1, r_n=1, sa=0, d_rise=d_fall=0, bw_n=all 1, every tap=0, trial counter=0, FSM=IDLE.
- Pattern sequence (P0,P1,P2,P3), all bits identical:
  - even trials: (0,1,1,0)
  - odd trials: (1,0,0,1)
- FSM states: IDLE, WR0, WR1, RD, WAIT, CAPTURE, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL: on start go to WR0 and clear done, fail, bit_fail and the trial counter. Start is ignored in every other state.
- WR0: w_n=0, d_rise=P0, d_fall=P1, bw_n=0.
- WR1: d_rise=P2, d_fall=P3, w_n=1, bw_n=0.
- RD: r_n=0 for exactly one cycle; call this cycle R.
- WAIT: count READ_LATENCY-1 cycles.
- CAPTURE: capture q_rise/q_fall into a window of MAX_SKEW+2 beats covering cycles R+READ_LATENCY .. R+READ_LATENCY+MAX_SKEW+1.
- CHECK, per bit i:
  - A candidate k (0..MAX_SKEW) matches when rise[k]=P0, fall[k]=P1, rise[k+1]=P2 and fall[k+1]=P3.
  - Exactly one match: the candidate for this trial is k.
  - Zero or more than one match: set bit_fail[i].
  - Trial 0 loads tap[i]. In later trials a candidate different from tap[i] sets bit_fail[i].
  - CHECK takes one cycle. It increments the trial counter, then goes to WR0 if trials remain, otherwise to DONE (bit_fail==0) or FAIL.
- DONE: done=1, held until the next start or reset. FAIL: fail=1, done=0, held likewise.
- Outside WR0/WR1 all write outputs hold their idle values: d=0, bw_n=all 1, w_n=1.
- Alignment datapath:
  - Each bit passes through a MAX_SKEW-deep shift register.
  - cal[i] = the input delayed by MAX_SKEW - tap[i] cycles (tap=MAX_SKEW gives a direct combinational pass).
  - Total read latency is therefore READ_LATENCY+MAX_SKEW for all bits.
  - Taps update only in CHECK of trial 0. While calibrating, cal outputs use the current taps.
  - Failing bits keep the trial-0 tap (0 if unmatched).
- Reset mid-calibration: abort immediately to the reset values; no further QDR strobes are issued.
- BYPASS=1: done=1, fail=0, bit_fail=0, w_n=r_n=1, bw_n=all 1, d_rise=all 1, d_fall=0, sa=0, cal=q (no delay).
- Total calibration time: NUM_TRIALS × (READ_LATENCY+MAX_SKEW+6) cycles, ±1 cycle per trial for the implementation's exact WAIT/CAPTURE boundary.

Test Plan:
- Memory model, latency 9, zero skew, defaults -> done=1 after 4 trials; all taps=0; cal latency = 12 cycles from the r_n low cycle; w_n pulses 4×, r_n pulses 4×.
- Bit 5 delayed +2 cycles, bit 17 delayed +3 -> tap[5]=2, tap[17]=3, others 0; a write of 0x2AAAA then a read returns 0x2AAAA aligned on cal outputs.
- Bit 3 stuck at 1 -> no match on even trials; fail=1, bit_fail=0x00008, done=0.
- Bit 9 skew toggles between 0 and 1 on alternate trials -> bit_fail[9]=1, fail=1.
- Assert reset during WAIT of trial 2 -> all outputs return to reset values within the same cycle; a new start completes with done=1.
- BYPASS=1 -> done=1 out of reset; q_rise=0x15555 appears on q_rise_cal the same cycle; w_n=r_n=1 permanently.

Source files
------------

// File: rtl/qdrc_phy_burst_align_multi_if.sv
// QDR burst-aligner bus bundle.
//   master : aligner side; drives the QDR write/read strobes, write data,
//            status flags and the aligned read data; receives start and the
//            raw bit-aligned read data.
//   slave  : controller/memory side; the mirror image of master.
interface qdrc_phy_burst_align_multi_if #(
   parameter int DATA_WIDTH = 18,
   parameter int BW_WIDTH   = 2,
   parameter int ADDR_WIDTH = 21
);
   logic                  burst_align_start;
   logic                  burst_align_done;
   logic                  burst_align_fail;
   logic [DATA_WIDTH-1:0] burst_align_bit_fail;
   logic [DATA_WIDTH-1:0] qdr_d_rise;
   logic [DATA_WIDTH-1:0] qdr_d_fall;
   logic [DATA_WIDTH-1:0] qdr_q_rise;
   logic [DATA_WIDTH-1:0] qdr_q_fall;
   logic [BW_WIDTH-1:0]   qdr_bw_n_rise;
   logic [BW_WIDTH-1:0]   qdr_bw_n_fall;
   logic                  qdr_w_n;
   logic                  qdr_r_n;
   logic [ADDR_WIDTH-1:0] qdr_sa;
   logic [DATA_WIDTH-1:0] qdr_q_rise_cal;
   logic [DATA_WIDTH-1:0] qdr_q_fall_cal;

   modport master (
      input  burst_align_start, qdr_q_rise, qdr_q_fall,
      output burst_align_done, burst_align_fail, burst_align_bit_fail,
             qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall,
             qdr_w_n, qdr_r_n, qdr_sa, qdr_q_rise_cal, qdr_q_fall_cal
   );

   modport slave (
      output burst_align_start, qdr_q_rise, qdr_q_fall,
      input  burst_align_done, burst_align_fail, burst_align_bit_fail,
             qdr_d_rise, qdr_d_fall, qdr_bw_n_rise, qdr_bw_n_fall,
             qdr_w_n, qdr_r_n, qdr_sa, qdr_q_rise_cal, qdr_q_fall_cal
   );
endinterface

// File: rtl/qdrc_phy_burst_align_multi.sv
// QDR PHY burst aligner. Writes a known DDR burst to address 0, reads it
// back NUM_TRIALS times, finds per data bit how many extra cycles (0..MAX_SKEW)
// that bit arrives late, and delays every bit so the whole read bus lands at
// READ_LATENCY+MAX_SKEW.
// Ports:
//   clk   : PHY clock
//   reset : asynchronous, active-high reset
//   bus   : master side of qdrc_phy_burst_align_multi_if (start/done/fail,
//           per-bit fail flags, QDR strobes/data/address, aligned read data)
//
// state   | meaning
// IDLE    | waiting for start
// WR0     | write strobe low, first burst half (P0/P1) on d
// WR1     | second burst half (P2/P3) on d
// RD      | read strobe low for one cycle (cycle R)
// WAIT    | READ_LATENCY-1 cycles of read latency
// CAPTURE | shift MAX_SKEW+2 read beats into the capture window
// CHECK   | per-bit match search, tap load (trial 0), fail accumulation
// DONE    | calibration passed, done held
// FAIL    | one or more bits failed, fail held
module qdrc_phy_burst_align_multi #(
   parameter int DATA_WIDTH   = 18,
   parameter int BW_WIDTH     = 2,
   parameter int ADDR_WIDTH   = 21,
   parameter int READ_LATENCY = 9,
   parameter int MAX_SKEW     = 3,
   parameter int NUM_TRIALS   = 4,
   parameter int BYPASS       = 0
) (
   input  logic clk,
   input  logic reset,
   qdrc_phy_burst_align_multi_if.master bus
);
   localparam int TW  = $clog2(MAX_SKEW + 1);
   localparam int TRW = $clog2(NUM_TRIALS + 1);
   localparam int CW  = $clog2(READ_LATENCY + MAX_SKEW + 2);
   localparam int NW  = MAX_SKEW + 2;

   typedef enum logic [3:0] {
      S_IDLE, S_WR0, S_WR1, S_RD, S_WAIT, S_CAPTURE, S_CHECK, S_DONE, S_FAIL
   } state_t;

   state_t                r_state;
   logic                  r_done;
   logic                  r_fail;
   logic [DATA_WIDTH-1:0] r_bit_fail;
   logic                  r_w_n;
   logic                  r_r_n;
   logic [DATA_WIDTH-1:0] r_d_rise;
   logic [DATA_WIDTH-1:0] r_d_fall;
   logic [BW_WIDTH-1:0]   r_bw_n;
   logic [TRW-1:0]        r_trial;
   logic [CW-1:0]         r_cnt;
   logic [TW-1:0]         r_tap      [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] r_win_rise [NW];
   logic [DATA_WIDTH-1:0] r_win_fall [NW];
   logic [DATA_WIDTH-1:0] r_sr_rise  [MAX_SKEW];
   logic [DATA_WIDTH-1:0] r_sr_fall  [MAX_SKEW];

   logic                  w_p0, w_p1, w_p2, w_p3;
   logic [DATA_WIDTH-1:0] w_one, w_multi, w_bad, w_bit_fail_nxt;
   logic [TW-1:0]         w_cand     [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] w_cal_rise, w_cal_fall;

   // Even trials send (0,1,1,0), odd trials the inverse (1,0,0,1).
   assign w_p0 = r_trial[0];
   assign w_p1 = ~r_trial[0];
   assign w_p2 = ~r_trial[0];
   assign w_p3 = r_trial[0];

   // Window slot 0 holds the beat from R+READ_LATENCY; candidate k needs the
   // first burst half in slot k and the second half in slot k+1.
   always_comb begin
      w_one   = '0;
      w_multi = '0;
      w_bad   = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         w_cand[i] = '0;
         for (int k = 0; k <= MAX_SKEW; k++) begin
            if (r_win_rise[k][i] == w_p0 && r_win_fall[k][i] == w_p1 &&
                r_win_rise[k+1][i] == w_p2 && r_win_fall[k+1][i] == w_p3) begin
               if (w_one[i]) w_multi[i] = 1'b1;
               w_one[i]  = 1'b1;
               w_cand[i] = TW'(k);
            end
         end
         w_bad[i] = ~w_one[i] | w_multi[i] |
                    ((r_trial != '0) && (w_cand[i] != r_tap[i]));
      end
   end

   assign w_bit_fail_nxt = r_bit_fail | w_bad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_fail     <= 1'b0;
         r_bit_fail <= '0;
         r_w_n      <= 1'b1;
         r_r_n      <= 1'b1;
         r_d_rise   <= '0;
         r_d_fall   <= '0;
         r_bw_n     <= '1;
         r_trial    <= '0;
         r_cnt      <= '0;
         for (int i = 0; i < DATA_WIDTH; i++) r_tap[i] <= '0;
         for (int j = 0; j < NW; j++) begin
            r_win_rise[j] <= '0;
            r_win_fall[j] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (bus.burst_align_start) begin
                  r_state    <= S_WR0;
                  r_done     <= 1'b0;
                  r_fail     <= 1'b0;
                  r_bit_fail <= '0;
                  r_trial    <= '0;
                  r_w_n      <= 1'b0;
                  r_bw_n     <= '0;
                  r_d_rise   <= '0;
                  r_d_fall   <= '1;
               end
            end
            S_WR0: begin
               r_state  <= S_WR1;
               r_w_n    <= 1'b1;
               r_d_rise <= {DATA_WIDTH{w_p2}};
               r_d_fall <= {DATA_WIDTH{w_p3}};
            end
            S_WR1: begin
               r_state  <= S_RD;
               r_d_rise <= '0;
               r_d_fall <= '0;
               r_bw_n   <= '1;
               r_r_n    <= 1'b0;
            end
            S_RD: begin
               r_state <= S_WAIT;
               r_r_n   <= 1'b1;
               r_cnt   <= CW'(READ_LATENCY - 2);
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= S_CAPTURE;
                  r_cnt   <= CW'(MAX_SKEW + 1);
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_CAPTURE: begin
               // Shift toward slot 0 so the earliest beat ends up at index 0.
               for (int j = 0; j < NW - 1; j++) begin
                  r_win_rise[j] <= r_win_rise[j+1];
                  r_win_fall[j] <= r_win_fall[j+1];
               end
               r_win_rise[NW-1] <= bus.qdr_q_rise;
               r_win_fall[NW-1] <= bus.qdr_q_fall;
               if (r_cnt == '0) r_state <= S_CHECK;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            S_CHECK: begin
               if (r_trial == '0) begin
                  for (int i = 0; i < DATA_WIDTH; i++)
                     r_tap[i] <= (w_one[i] & ~w_multi[i]) ? w_cand[i] : '0;
               end
               r_bit_fail <= w_bit_fail_nxt;
               r_trial    <= r_trial + 1'b1;
               if (r_trial == TRW'(NUM_TRIALS - 1)) begin
                  if (w_bit_fail_nxt == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_FAIL;
                     r_fail  <= 1'b1;
                  end
               end else begin
                  // Next trial flips parity, so P0 = new parity, P1 = its inverse.
                  r_state  <= S_WR0;
                  r_w_n    <= 1'b0;
                  r_bw_n   <= '0;
                  r_d_rise <= {DATA_WIDTH{~r_trial[0]}};
                  r_d_fall <= {DATA_WIDTH{r_trial[0]}};
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Delay line: r_sr_*[j] is the input delayed by j+1 cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < MAX_SKEW; j++) begin
            r_sr_rise[j] <= '0;
            r_sr_fall[j] <= '0;
         end
      end else begin
         r_sr_rise[0] <= bus.qdr_q_rise;
         r_sr_fall[0] <= bus.qdr_q_fall;
         for (int j = 1; j < MAX_SKEW; j++) begin
            r_sr_rise[j] <= r_sr_rise[j-1];
            r_sr_fall[j] <= r_sr_fall[j-1];
         end
      end
   end

   // A bit found tap cycles late needs MAX_SKEW-tap more; tap=MAX_SKEW passes straight through.
   always_comb begin
      w_cal_rise = bus.qdr_q_rise;
      w_cal_fall = bus.qdr_q_fall;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         for (int j = 0; j < MAX_SKEW; j++) begin
            if (r_tap[i] == TW'(MAX_SKEW - 1 - j)) begin
               w_cal_rise[i] = r_sr_rise[j][i];
               w_cal_fall[i] = r_sr_fall[j][i];
            end
         end
      end
   end

   localparam bit BYP = (BYPASS != 0);

   assign bus.burst_align_done     = BYP ? 1'b1 : r_done;
   assign bus.burst_align_fail     = BYP ? 1'b0 : r_fail;
   assign bus.burst_align_bit_fail = BYP ? '0   : r_bit_fail;
   assign bus.qdr_w_n              = BYP ? 1'b1 : r_w_n;
   assign bus.qdr_r_n              = BYP ? 1'b1 : r_r_n;
   assign bus.qdr_d_rise           = BYP ? '1   : r_d_rise;
   assign bus.qdr_d_fall           = BYP ? '0   : r_d_fall;
   assign bus.qdr_bw_n_rise        = BYP ? '1   : r_bw_n;
   assign bus.qdr_bw_n_fall        = BYP ? '1   : r_bw_n;
   assign bus.qdr_sa               = '0;
   assign bus.qdr_q_rise_cal       = BYP ? bus.qdr_q_rise : w_cal_rise;
   assign bus.qdr_q_fall_cal       = BYP ? bus.qdr_q_fall : w_cal_fall;
endmodule

// File: tb/tb_qdrc_phy_burst_align_multi.sv
module tb_qdrc_phy_burst_align_multi;
   localparam int DW = 18;
   localparam int BW = 2;
   localparam int AW = 21;
   localparam int RL = 9;
   localparam int MS = 3;
   localparam int NT = 4;
   localparam logic [DW-1:0] ONES = '1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   qdrc_phy_burst_align_multi_if #(.DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW)) m_if ();
   qdrc_phy_burst_align_multi_if #(.DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW)) b_if ();

   qdrc_phy_burst_align_multi #(
      .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
      .MAX_SKEW(MS), .NUM_TRIALS(NT), .BYPASS(0)
   ) dut (.clk(clk), .reset(reset), .bus(m_if));

   qdrc_phy_burst_align_multi #(
      .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
      .MAX_SKEW(MS), .NUM_TRIALS(NT), .BYPASS(1)
   ) dut_byp (.clk(clk), .reset(reset), .bus(b_if));

   int n_chk = 0;
   int n_err = 0;

   typedef struct { string nm; logic dn; logic fl; logic [DW-1:0] bf; } exp_t;
   typedef struct { string nm; int c; logic [DW-1:0] r; logic [DW-1:0] f; } cal_t;
   exp_t sb[$];
   cal_t cq[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // memory / skew model state
   int cyc = 0;
   int rcyc = -1000, rtrial = 0, wcyc = -1000, wpar = 0;
   int wcount = 0, rcount = 0, tstart = 0;
   logic [DW-1:0] m_r0 = '0, m_f0 = '0, m_r1 = '0, m_f1 = '0;
   int u_cyc = -1000;
   logic [DW-1:0] u_r0 = '0, u_f0 = '0, u_r1 = '0, u_f1 = '0;
   int skew [DW];
   bit tog9 = 1'b0;
   logic [DW-1:0] stuck1 = '0;

   // Drives q for the new cycle shortly after each rising edge.
   initial begin
      logic [DW-1:0] qr, qf;
      m_if.qdr_q_rise = '0;
      m_if.qdr_q_fall = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         qr = '0;
         qf = '0;
         for (int i = 0; i < DW; i++) begin
            int sk, d, du;
            sk = skew[i] + ((tog9 && i == 9 && (rtrial % 2 == 1)) ? 1 : 0);
            d  = cyc - rcyc - RL - sk;
            du = cyc - u_cyc - RL - skew[i];
            if (d == 0)  begin qr[i] = m_r0[i]; qf[i] = m_f0[i]; end
            if (d == 1)  begin qr[i] = m_r1[i]; qf[i] = m_f1[i]; end
            if (du == 0) begin qr[i] = qr[i] | u_r0[i]; qf[i] = qf[i] | u_f0[i]; end
            if (du == 1) begin qr[i] = qr[i] | u_r1[i]; qf[i] = qf[i] | u_f1[i]; end
         end
         m_if.qdr_q_rise = qr | stuck1;
         m_if.qdr_q_fall = qf | stuck1;
      end
   end

   // Observes strobes mid-cycle: stores written burst, records read cycles, checks bus values.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (m_if.burst_align_start) begin
               wcount = 0;
               rcount = 0;
               tstart = cyc;
            end
            if (!m_if.qdr_w_n) begin
               wpar = wcount % 2;
               check("wr0_d_rise", m_if.qdr_d_rise, wpar ? ONES : '0);
               check("wr0_d_fall", m_if.qdr_d_fall, wpar ? '0 : ONES);
               check("wr0_bw_n", {m_if.qdr_bw_n_rise, m_if.qdr_bw_n_fall}, 0);
               m_r0 = m_if.qdr_d_rise;
               m_f0 = m_if.qdr_d_fall;
               wcyc = cyc;
               wcount++;
            end
            if (cyc == wcyc + 1) begin
               check("wr1_d_rise", m_if.qdr_d_rise, wpar ? '0 : ONES);
               check("wr1_d_fall", m_if.qdr_d_fall, wpar ? ONES : '0);
               check("wr1_bw_n", {m_if.qdr_bw_n_rise, m_if.qdr_bw_n_fall}, 0);
               m_r1 = m_if.qdr_d_rise;
               m_f1 = m_if.qdr_d_fall;
            end
            if (!m_if.qdr_r_n) begin
               check("rd_idle_d", {m_if.qdr_d_rise, m_if.qdr_d_fall}, 0);
               check("rd_idle_bw_n", {m_if.qdr_bw_n_rise, m_if.qdr_bw_n_fall}, 4'hF);
               check("rd_sa", m_if.qdr_sa, 0);
               rcyc = cyc;
               rtrial = rcount;
               rcount++;
            end
         end
      end
   end

   // Monitor: end-of-calibration scoreboard and timed aligned-data checks.
   initial begin
      logic prev = 1'b0;
      logic cur;
      exp_t e;
      cal_t c;
      int el;
      forever begin
         @(negedge clk);
         cur = m_if.burst_align_done | m_if.burst_align_fail;
         if (cur && !prev && !reset) begin
            check("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check({e.nm, "_done"}, m_if.burst_align_done, e.dn);
               check({e.nm, "_fail"}, m_if.burst_align_fail, e.fl);
               check({e.nm, "_bit_fail"}, m_if.burst_align_bit_fail, e.bf);
               check({e.nm, "_w_pulses"}, wcount, NT);
               check({e.nm, "_r_pulses"}, rcount, NT);
               el = cyc - tstart;
               n_chk++;
               if (el < NT * (RL + MS + 5) || el > NT * (RL + MS + 7)) begin
                  n_err++;
                  $display("FAIL %s_cal_time: got %0d cycles expected %0d..%0d",
                           e.nm, el, NT * (RL + MS + 5), NT * (RL + MS + 7));
               end
            end
         end
         prev = cur;
         while (cq.size() > 0 && cq[0].c <= cyc) begin
            c = cq.pop_front();
            if (c.c == cyc) begin
               check({c.nm, "_rise"}, m_if.qdr_q_rise_cal, c.r);
               check({c.nm, "_fall"}, m_if.qdr_q_fall_cal, c.f);
            end else begin
               check({c.nm, "_missed_cycle"}, cyc, c.c);
            end
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #2;
      m_if.burst_align_start = 1'b1;
      @(posedge clk); #2;
      m_if.burst_align_start = 1'b0;
   endtask

   task automatic run_cal(input string nm, input logic dn, input logic fl, input logic [DW-1:0] bf);
      int n;
      exp_t e;
      e.nm = nm; e.dn = dn; e.fl = fl; e.bf = bf;
      sb.push_back(e);
      pulse_start();
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_if.burst_align_done | m_if.burst_align_fail) && n < 200);
      check({nm, "_finished"}, m_if.burst_align_done | m_if.burst_align_fail, 1);
      @(negedge clk);
      if (!(m_if.burst_align_done | m_if.burst_align_fail)) sb.delete();
   endtask

   task automatic user_read(input string nm, input logic [DW-1:0] r0, input logic [DW-1:0] f0,
                            input logic [DW-1:0] r1, input logic [DW-1:0] f1);
      cal_t c;
      @(posedge clk); #2;
      u_r0 = r0; u_f0 = f0; u_r1 = r1; u_f1 = f1;
      u_cyc = cyc + 2;
      c.nm = {nm, "_pre"};   c.c = u_cyc + RL + MS - 1; c.r = '0; c.f = '0; cq.push_back(c);
      c.nm = {nm, "_beat0"}; c.c = u_cyc + RL + MS;     c.r = r0; c.f = f0; cq.push_back(c);
      c.nm = {nm, "_beat1"}; c.c = u_cyc + RL + MS + 1; c.r = r1; c.f = f1; cq.push_back(c);
      repeat (RL + MS + 6) @(negedge clk);
   endtask

   task automatic chk_reset(input string t);
      check({t, "_done"}, m_if.burst_align_done, 0);
      check({t, "_fail"}, m_if.burst_align_fail, 0);
      check({t, "_bit_fail"}, m_if.burst_align_bit_fail, 0);
      check({t, "_w_n"}, m_if.qdr_w_n, 1);
      check({t, "_r_n"}, m_if.qdr_r_n, 1);
      check({t, "_sa"}, m_if.qdr_sa, 0);
      check({t, "_d"}, {m_if.qdr_d_rise, m_if.qdr_d_fall}, 0);
      check({t, "_bw_n"}, {m_if.qdr_bw_n_rise, m_if.qdr_bw_n_fall}, 4'hF);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic strobes;
      int n;
      for (int i = 0; i < DW; i++) skew[i] = 0;
      reset = 1'b1;
      m_if.burst_align_start = 1'b0;
      b_if.burst_align_start = 1'b0;
      b_if.qdr_q_rise = '0;
      b_if.qdr_q_fall = '0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      chk_reset("post_reset");

      // bypass instance
      check("byp_done", b_if.burst_align_done, 1);
      check("byp_fail", b_if.burst_align_fail, 0);
      check("byp_bit_fail", b_if.burst_align_bit_fail, 0);
      check("byp_d_rise", b_if.qdr_d_rise, ONES);
      check("byp_d_fall", b_if.qdr_d_fall, 0);
      check("byp_bw_n", {b_if.qdr_bw_n_rise, b_if.qdr_bw_n_fall}, 4'hF);
      @(posedge clk); #2;
      b_if.qdr_q_rise = 18'h15555;
      b_if.qdr_q_fall = 18'h2AAAA;
      #1;
      check("byp_cal_rise", b_if.qdr_q_rise_cal, 18'h15555);
      check("byp_cal_fall", b_if.qdr_q_fall_cal, 18'h2AAAA);
      b_if.burst_align_start = 1'b1;
      @(posedge clk); #2;
      b_if.burst_align_start = 1'b0;
      strobes = 1'b1;
      repeat (8) begin
         @(negedge clk);
         strobes = strobes & b_if.qdr_w_n & b_if.qdr_r_n;
      end
      check("byp_strobes_idle", strobes, 1);

      // zero skew
      run_cal("zero_skew", 1'b1, 1'b0, '0);
      user_read("zero_skew_read", 18'h15555, 18'h2AAAA, 18'h0F0F0, 18'h30303);

      // bit 5 +2, bit 17 +3
      skew[5] = 2;
      skew[17] = 3;
      run_cal("skew_5_17", 1'b1, 1'b0, '0);
      user_read("skew_read", 18'h2AAAA, 18'h15555, 18'h0F0F0, 18'h30303);
      skew[5] = 0;
      skew[17] = 0;

      // bit 3 stuck at 1
      stuck1 = 18'h00008;
      run_cal("stuck3", 1'b0, 1'b1, 18'h00008);
      stuck1 = '0;

      // bit 9 skew alternates 0/1
      tog9 = 1'b1;
      run_cal("toggle9", 1'b0, 1'b1, 18'h00200);
      tog9 = 1'b0;

      // reset during WAIT of trial 2
      pulse_start();
      n = 0;
      while (rcount < 3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reached_trial2_rd", rcount, 3);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk_reset("mid_reset");
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("no_rd_after_reset", rcount, 3);
      check("no_wr_after_reset", wcount, 3);
      run_cal("after_reset", 1'b1, 1'b0, '0);
      user_read("after_reset_read", 18'h3C3C3, 18'h03C3C, 18'h11111, 18'h22222);

      repeat (5) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      check("cal_q_drained", cq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
